serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 38 +++
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The w_sub field exists only when SERADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int unsigned P_WIDTH = 8
);
    logic               w_in_valid;
    logic               w_in_ready;
    logic [P_WIDTH-1:0] w_a;
    logic [P_WIDTH-1:0] w_b;
`ifdef SERADD_SUB_EN
    logic               w_sub;
`endif
    logic               w_out_valid;
    logic               w_out_ready;
    logic [P_WIDTH-1:0] w_s;
    logic               w_cout;
    logic               w_busy;

`ifdef SERADD_SUB_EN
    modport slave (
        input  w_in_valid, w_a, w_b, w_sub, w_out_ready,
        output w_in_ready, w_out_valid, w_s, w_cout, w_busy
    );
    modport master (
        output w_in_valid, w_a, w_b, w_sub, w_out_ready,
        input  w_in_ready, w_out_valid, w_s, w_cout, w_busy
    );
`else
    modport slave (
        input  w_in_valid, w_a, w_b, w_out_ready,
        output w_in_ready, w_out_valid, w_s, w_cout, w_busy
    );
    modport master (
        output w_in_valid, w_a, w_b, w_out_ready,
        input  w_in_ready, w_out_valid, w_s, w_cout, w_busy
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, one bit per clock, LSB first.
// Define SERADD_SUB_EN to add the w_sub port (A-B via inverted B and carry-in 1).
module serial_add_ctrl #(
    parameter int unsigned P_WIDTH = 8
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    serial_add_ctrl_if.slave     bus
);
    localparam int unsigned CNT_W = (P_WIDTH > 2) ? $clog2(P_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [P_WIDTH-1:0] a_q, a_d;
    logic [P_WIDTH-1:0] b_q, b_d;
    logic [P_WIDTH-1:0] s_q, s_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, out_valid_q, busy_q;
    logic               sub_c;
    logic               sum_c;
    logic               carry_c;

`ifdef SERADD_SUB_EN
    assign sub_c = bus.w_sub;
`else
    assign sub_c = 1'b0;
`endif

    // The single shared full-adder cell
    assign sum_c   = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.w_in_valid && in_ready_q) begin
                    state_d = S_RUN;
                    a_d     = bus.w_a;
                    b_d     = sub_c ? ~bus.w_b : bus.w_b;
                    c_d     = sub_c;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                s_d   = {sum_c, s_q[P_WIDTH-1:1]};
                c_d   = carry_c;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(P_WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.w_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake flags are registered copies of the next-state decode
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d == S_RUN);
        end
    end

    assign bus.w_in_ready  = in_ready_q;
    assign bus.w_out_valid = out_valid_q;
    assign bus.w_busy      = busy_q;
    assign bus.w_s         = s_q;
    assign bus.w_cout      = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: two instances (N=4 at index 0, N=8 at index 1)
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    logic [1:0]       vld;
    logic [1:0]       ordy;
    logic [1:0]       sub;
    logic [1:0][31:0] opa;
    logic [1:0][31:0] opb;

    serial_add_ctrl_if #(.P_WIDTH(4)) if4 ();
    serial_add_ctrl_if #(.P_WIDTH(8)) if8 ();

    assign if4.w_in_valid  = vld[0];
    assign if4.w_a         = opa[0][3:0];
    assign if4.w_b         = opb[0][3:0];
    assign if4.w_out_ready = ordy[0];
    assign if8.w_in_valid  = vld[1];
    assign if8.w_a         = opa[1][7:0];
    assign if8.w_b         = opb[1][7:0];
    assign if8.w_out_ready = ordy[1];
`ifdef SERADD_SUB_EN
    assign if4.w_sub = sub[0];
    assign if8.w_sub = sub[1];
`endif

    serial_add_ctrl #(.P_WIDTH(4)) dut4 (.w_clk(clk), .w_rst_n(rst_n), .bus(if4));
    serial_add_ctrl #(.P_WIDTH(8)) dut8 (.w_clk(clk), .w_rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nw(input int i);
        return (i == 0) ? 4 : 8;
    endfunction
    function automatic logic ob_ready(input int i);
        return (i == 0) ? if4.w_in_ready : if8.w_in_ready;
    endfunction
    function automatic logic ob_valid(input int i);
        return (i == 0) ? if4.w_out_valid : if8.w_out_valid;
    endfunction
    function automatic logic ob_busy(input int i);
        return (i == 0) ? if4.w_busy : if8.w_busy;
    endfunction
    function automatic logic ob_cout(input int i);
        return (i == 0) ? if4.w_cout : if8.w_cout;
    endfunction
    function automatic logic [31:0] ob_s(input int i);
        return (i == 0) ? 32'(if4.w_s) : 32'(if8.w_s);
    endfunction

    // Reference: plain modular arithmetic on N-bit unsigned values
    function automatic void ref_op(input int n, input logic [31:0] a, input logic [31:0] b,
                                   input logic sb, output logic [31:0] s, output logic co);
        logic [63:0] m;
        logic [63:0] t;
        m = (64'd1 << n) - 64'd1;
        if (sb) begin
            s  = 32'((64'(a) - 64'(b)) & m);
            co = (a >= b);
        end else begin
            t  = 64'(a) + 64'(b);
            s  = 32'(t & m);
            co = t[n];
        end
    endfunction

    // Drives one transaction from a negedge; returns at the negedge after consumption
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic sb, input int hold, input logic [31:0] alt,
                          output logic [31:0] s, output logic co, output int lat,
                          output int busy_n, output int acc_cyc,
                          output logic hold_ok, output logic done_ok);
        int w;
        opa[i]  = a;
        opb[i]  = b;
        sub[i]  = sb;
        vld[i]  = 1'b1;
        ordy[i] = (hold == 0);
        w = 0;
        while (!ob_ready(i) && w < 50) begin
            @(posedge clk); @(negedge clk);
            w++;
        end
        @(posedge clk); @(negedge clk);
        acc_cyc = cyc;
        vld[i]  = 1'b0;
        lat     = 0;
        busy_n  = 0;
        while (!ob_valid(i) && lat < 100) begin
            if (ob_busy(i)) busy_n++;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        s       = ob_s(i);
        co      = ob_cout(i);
        hold_ok = 1'b1;
        for (int k = 0; k < hold; k++) begin
            vld[i] = (k == 0);
            opa[i] = alt;
            opb[i] = alt;
            @(posedge clk); @(negedge clk);
            if (!ob_valid(i) || ob_ready(i) || ob_s(i) !== s || ob_cout(i) !== co)
                hold_ok = 1'b0;
        end
        vld[i]  = 1'b0;
        ordy[i] = 1'b1;
        @(posedge clk); @(negedge clk);
        done_ok = ob_ready(i) && !ob_valid(i) && !ob_busy(i);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp += 5;
            if (ob_ready(i) !== 1'b1) begin n_bad++; $display("FAIL reset_ready[%0d] got %b want 1", i, ob_ready(i)); end
            if (ob_valid(i) !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d] got %b want 0", i, ob_valid(i)); end
            if (ob_busy(i) !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d] got %b want 0", i, ob_busy(i)); end
            if (ob_s(i) !== 32'd0) begin n_bad++; $display("FAIL reset_s[%0d] got %0d want 0", i, ob_s(i)); end
            if (ob_cout(i) !== 1'b0) begin n_bad++; $display("FAIL reset_cout[%0d] got %b want 0", i, ob_cout(i)); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] s; logic co, hok, dok; int lat, bn, ac;
        run_op(0, 32'd3, 32'd4, 1'b0, 0, 32'd0, s, co, lat, bn, ac, hok, dok);
        n_cmp += 4;
        if (s !== 32'd7) begin n_bad++; $display("FAIL lat_s got %0d want 7", s); end
        if (co !== 1'b0) begin n_bad++; $display("FAIL lat_cout got %b want 0", co); end
        if (lat !== 4) begin n_bad++; $display("FAIL lat_cycles got %0d want 4", lat); end
        if (dok !== 1'b1) begin n_bad++; $display("FAIL lat_consume got %b want 1", dok); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[3] = '{32'd1, 32'd8, 32'd15};
        logic [31:0] pb[3] = '{32'd9, 32'd9, 32'd1};
        logic [31:0] es[3] = '{32'd10, 32'd1, 32'd0};
        logic        ec[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] s; logic co, hok, dok; int lat, bn, ac, prev;
        prev = 0;
        for (int p = 0; p < 3; p++) begin
            run_op(0, pa[p], pb[p], 1'b0, 0, 32'd0, s, co, lat, bn, ac, hok, dok);
            n_cmp += 2;
            if (s !== es[p]) begin n_bad++; $display("FAIL b2b_s[%0d] got %0d want %0d", p, s, es[p]); end
            if (co !== ec[p]) begin n_bad++; $display("FAIL b2b_cout[%0d] got %b want %b", p, co, ec[p]); end
            if (p > 0) begin
                n_cmp++;
                if (ac - prev !== 6) begin n_bad++; $display("FAIL b2b_spacing[%0d] got %0d want 6", p, ac - prev); end
            end
            prev = ac;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s; logic co, hok, dok; int lat, bn, ac;
        run_op(0, 32'd3, 32'd4, 1'b0, 5, 32'd5, s, co, lat, bn, ac, hok, dok);
        n_cmp += 3;
        if (s !== 32'd7) begin n_bad++; $display("FAIL bp_s got %0d want 7", s); end
        if (hok !== 1'b1) begin n_bad++; $display("FAIL bp_hold got %b want 1", hok); end
        if (dok !== 1'b1) begin n_bad++; $display("FAIL bp_ignore_valid got %b want 1", dok); end
    endtask

    task automatic test_full_width();
        logic [31:0] s; logic co, hok, dok; int lat, bn, ac;
        run_op(1, 32'd255, 32'd255, 1'b0, 0, 32'd0, s, co, lat, bn, ac, hok, dok);
        n_cmp += 4;
        if (s !== 32'd254) begin n_bad++; $display("FAIL fw_s got %0d want 254", s); end
        if (co !== 1'b1) begin n_bad++; $display("FAIL fw_cout got %b want 1", co); end
        if (bn !== 8) begin n_bad++; $display("FAIL fw_busy_cycles got %0d want 8", bn); end
        if (lat !== 8) begin n_bad++; $display("FAIL fw_lat got %0d want 8", lat); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] s; logic co, hok, dok; int lat, bn, ac, seen;
        run_op(1, 32'd200, 32'd100, 1'b0, 0, 32'd0, s, co, lat, bn, ac, hok, dok);
        n_cmp += 2;
        if (s !== 32'd44) begin n_bad++; $display("FAIL mr_s got %0d want 44", s); end
        if (co !== 1'b1) begin n_bad++; $display("FAIL mr_cout got %b want 1", co); end
        opa[1] = 32'd200; opb[1] = 32'd100; sub[1] = 1'b0; vld[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        vld[1] = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (if8.w_in_ready !== 1'b1) begin n_bad++; $display("FAIL mr_ready got %b want 1", if8.w_in_ready); end
        if (if8.w_out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid got %b want 0", if8.w_out_valid); end
        if (if8.w_busy !== 1'b0) begin n_bad++; $display("FAIL mr_busy got %b want 0", if8.w_busy); end
        if (if8.w_s !== 8'd0) begin n_bad++; $display("FAIL mr_s_rst got %0d want 0", if8.w_s); end
        if (if8.w_cout !== 1'b0) begin n_bad++; $display("FAIL mr_cout_rst got %b want 0", if8.w_cout); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); @(negedge clk);
            if (if8.w_out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL mr_no_result got %0d valid cycles want 0", seen); end
    endtask

`ifdef SERADD_SUB_EN
    task automatic test_sub();
        logic [31:0] s; logic co, hok, dok; int lat, bn, ac;
        run_op(0, 32'd9, 32'd4, 1'b1, 0, 32'd0, s, co, lat, bn, ac, hok, dok);
        n_cmp += 2;
        if (s !== 32'd5) begin n_bad++; $display("FAIL sub1_s got %0d want 5", s); end
        if (co !== 1'b1) begin n_bad++; $display("FAIL sub1_cout got %b want 1", co); end
        run_op(0, 32'd3, 32'd4, 1'b1, 0, 32'd0, s, co, lat, bn, ac, hok, dok);
        n_cmp += 2;
        if (s !== 32'd15) begin n_bad++; $display("FAIL sub2_s got %0d want 15", s); end
        if (co !== 1'b0) begin n_bad++; $display("FAIL sub2_cout got %b want 0", co); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] s, es, a, b, m; logic co, ec, sb, hok, dok; int lat, bn, ac, i, n;
        for (int t = 0; t < 30; t++) begin
            i  = int'($urandom_range(0, 1));
            n  = nw(i);
            m  = (32'd1 << n) - 32'd1;
            a  = $urandom & m;
            b  = $urandom & m;
`ifdef SERADD_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            ref_op(n, a, b, sb, es, ec);
            run_op(i, a, b, sb, int'($urandom_range(0, 2)), $urandom & m,
                   s, co, lat, bn, ac, hok, dok);
            n_cmp += 4;
            if (s !== es) begin n_bad++; $display("FAIL rnd_s[%0d] n=%0d a=%0d b=%0d sub=%b got %0d want %0d", t, n, a, b, sb, s, es); end
            if (co !== ec) begin n_bad++; $display("FAIL rnd_cout[%0d] got %b want %b", t, co, ec); end
            if (lat !== n) begin n_bad++; $display("FAIL rnd_lat[%0d] got %0d want %0d", t, lat, n); end
            if (hok !== 1'b1 || dok !== 1'b1) begin n_bad++; $display("FAIL rnd_handshake[%0d] got hold=%b done=%b want 1 1", t, hok, dok); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc   = 0;
        rst_n = 1'b0;
        vld   = '0;
        ordy  = '0;
        sub   = '0;
        opa   = '0;
        opb   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_full_width();
        test_reset_mid_run();
`ifdef SERADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
